ads131_spi_responder: RTL and testbench
=======================================

// Module: ads131_spi_responder
// PURPOSE
//  Synthesizable ADS131A0X SPI slave model: the far end of the ADC SPI master. Samples SCLK/CS/MOSI and
//  returns ADC-style responses on MISO, using the ADC's previous-frame response rule and lock state.
//  Used on-FPGA and in benches as a loopback target for the master before real ADC silicon is attached.
// PARAMETERS
//  WORD_BITS   32  bits per SPI frame; command/response occupy the upper 16, the lower 16 are 0 on MISO
//  SYNC_STAGES 2   synchronizer flops on SPI_SCLK, SPI_CS, SPI_MOSI and SPI_RESET (minimum 2)
// PORTS
//  system_clock  in   1   50 MHz system clock; the only clock
//  reset_n       in   1   asynchronous, active-low reset
//  SPI_SCLK      in   1   SPI clock from master, CPOL=0
//  SPI_CS        in   1   chip select, active low
//  SPI_MOSI      in   1   master data, MSB first
//  SPI_MISO      out  1   response data, MSB first
//  SPI_RESET     in   1   ADC reset pin, active low (synchronous after sync stages)
//  cmd_word      out  16  last decoded command (upper 16 bits of frame)
//  cmd_valid     out  1   1-cycle pulse when cmd_word updates
//  locked        out  1   1 = device locked
//  state         out  2   debug: current FSM state
// BEHAVIOUR
//  Reset (reset_n low or synced SPI_RESET low): SPI_MISO=0, cmd_word=0, cmd_valid=0, locked=1, state=HOLD,
//   regfile[0..31]=0x00, ready_flag=1, next_resp=0xFF04. Any frame in progress is aborted; nothing decoded.
//  Inputs pass SYNC_STAGES flops, then edge detect; master SCLK half-period must be >= 4 system clocks.
//  FSM: HOLD -> IDLE when SPI_RESET high. IDLE -> SHIFT on CS fall (load shift_out={next_resp,16'h0},
//   bit_cnt=0). SHIFT: SCLK rise -> SPI_MISO=shift_out[MSB], shift left; SCLK fall -> shift_in<={shift_in,MOSI},
//   bit_cnt++. SHIFT -> DECODE on CS rise. DECODE (1 cycle) -> IDLE.
//  MISO launched within SYNC_STAGES+1 clocks of SCLK rise; held 0 while CS high.
//  DECODE (only if bit_cnt==WORD_BITS; else frame dropped, state unchanged): c=shift_in[WORD_BITS-1 -: 16];
//   cmd_word=c, cmd_valid pulses same cycle; next_resp set for the FOLLOWING frame:
//   0x0000 NULL   -> ready_flag ? 0xFF04 : 0x2200
//   0x0655 UNLOCK -> 0x0655; locked=0; ready_flag=0
//   0x0555 LOCK   -> 0x0555; locked=1
//   001a_aaaa_xxxx_xxxx RREG -> {3'b001,a,regfile[a]}
//   010a_aaaa_dddd_dddd WREG -> unlocked: regfile[a]=d, resp {3'b001,a,d}; locked: no write, resp as NULL
//   any other   -> as NULL
//  bit_cnt saturates at WORD_BITS+1 (over-long frame dropped, never wraps to look valid).
//  CS rise and SCLK edge in same cycle: edge processed first, then CS rise.
// CONFIGURATION
//  ADS_RESP_FRAME_ERR_EN defined: adds output frame_err (1): 1-cycle pulse in DECODE when bit_cnt!=WORD_BITS;
//   also forces next_resp=0x0000 after a bad frame. Undefined: port absent, bad frames silently dropped.
// STRUCTURE
//  Package ads131_resp_pkg: opcode constants (NULL, UNLOCK, LOCK, RREG/WREG prefixes), response constants
//   (0xFF04 READY, 0x2200 STATUS), FSM state encoding.
//  Sub-module ads131_spi_sync: SYNC_STAGES synchronizer plus rise/fall detect on one input; 4 instances.
// TESTING
//  Reset, NULL frame -> MISO returns 0xFF04_0000 on second frame; locked=1, cmd_word=0x0000.
//  UNLOCK 0x0655_0000 then NULL -> second-frame MISO 0x0655_0000, locked=0; third NULL -> 0x2200_0000.
//  Unlocked WREG 0x4305 (addr 3, data 0x05) then RREG 0x2300 -> responses 0x2305 then 0x2305.
//  Locked WREG 0x4305 -> regfile[3] stays 0x00; next RREG 0x2300 -> 0x2300.
//  CS raised after 20 SCLKs -> cmd_valid stays 0, next_resp unchanged (frame_err pulses if macro defined).
//  SPI_RESET low mid-frame -> MISO=0, state=HOLD, locked=1; next frame returns 0xFF04_0000.

Source files
------------

// File: rtl/ads131_resp_pkg.sv
// ADS131A0X SPI responder: opcodes, response words and FSM encoding.
// Shared by ads131_spi_responder and its bench.
`timescale 1ns/1ps
package ads131_resp_pkg;

    localparam logic [15:0] OP_NULL     = 16'h0000;
    localparam logic [15:0] OP_UNLOCK   = 16'h0655;
    localparam logic [15:0] OP_LOCK     = 16'h0555;
    localparam logic [2:0]  OP_RREG_PFX = 3'b001;
    localparam logic [2:0]  OP_WREG_PFX = 3'b010;

    localparam logic [15:0] RESP_READY  = 16'hFF04;
    localparam logic [15:0] RESP_STATUS = 16'h2200;

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_DECODE = 2'd3;

    // NULL-class reply depends on whether the power-up ready word is pending
    function automatic logic [15:0] null_resp(input logic ready);
        return ready ? RESP_READY : RESP_STATUS;
    endfunction

endpackage

// File: rtl/ads131_spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin,
// with single-cycle rise/fall strobes on the synchronized level.
`timescale 1ns/1ps
module ads131_spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the pin through the chain; remember the last synced level
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Chain and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/ads131_spi_responder.sv
// ADS131A0X SPI slave model: answers each frame with the reply set up by the previous one.
// Optional ADS_RESP_FRAME_ERR_EN adds a frame_err pulse and a 0x0000 reply after bad frames.
`timescale 1ns/1ps
module ads131_spi_responder
    import ads131_resp_pkg::*;
#(
    parameter int WORD_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic        SPI_SCLK,
    input  logic        SPI_CS,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
    input  logic        SPI_RESET,
    output logic [15:0] cmd_word,
    output logic        cmd_valid,
    output logic        locked,
    output logic [1:0]  state
`ifdef ADS_RESP_FRAME_ERR_EN
    ,
    output logic        frame_err
`endif
);

    localparam int CNT_W = $clog2(WORD_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s, rst_s;
    logic sclk_lvl_unused, cs_lvl_unused;
    logic mosi_rise_unused, mosi_fall_unused;
    logic rst_rise_unused, rst_fall_unused;

    ads131_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(system_clock), .rst_n(reset_n), .d(SPI_SCLK),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    ads131_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(system_clock), .rst_n(reset_n), .d(SPI_CS),
        .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );
    ads131_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(system_clock), .rst_n(reset_n), .d(SPI_MOSI),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );
    ads131_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_rst (
        .clk(system_clock), .rst_n(reset_n), .d(SPI_RESET),
        .q(rst_s), .rise(rst_rise_unused), .fall(rst_fall_unused)
    );

    logic [1:0]           state_q, state_d;
    logic                 miso_q, miso_d;
    logic [15:0]          cmd_word_q, cmd_word_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 locked_q, locked_d;
    logic                 ready_q, ready_d;
    logic [15:0]          next_resp_q, next_resp_d;
    logic [WORD_BITS-1:0] shift_out_q, shift_out_d;
    logic [WORD_BITS-1:0] shift_in_q, shift_in_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [31:0][7:0]     regfile_q, regfile_d;
`ifdef ADS_RESP_FRAME_ERR_EN
    logic                 frame_err_q, frame_err_d;
`endif

    logic [15:0] c;
    logic [4:0]  addr;
    assign c    = shift_in_q[WORD_BITS-1 -: 16];
    assign addr = c[12:8];

    // Frame FSM: shift on synced SCLK edges, decode the command on CS rise
    always_comb begin
        state_d     = state_q;
        miso_d      = miso_q;
        cmd_word_d  = cmd_word_q;
        cmd_valid_d = 1'b0;
        locked_d    = locked_q;
        ready_d     = ready_q;
        next_resp_d = next_resp_q;
        shift_out_d = shift_out_q;
        shift_in_d  = shift_in_q;
        bit_cnt_d   = bit_cnt_q;
        regfile_d   = regfile_q;
`ifdef ADS_RESP_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif
        if (!rst_s) begin
            state_d     = ST_HOLD;
            miso_d      = 1'b0;
            cmd_word_d  = 16'h0000;
            locked_d    = 1'b1;
            ready_d     = 1'b1;
            next_resp_d = RESP_READY;
            bit_cnt_d   = '0;
            regfile_d   = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: state_d = ST_IDLE;
                ST_IDLE: begin
                    miso_d = 1'b0;
                    if (cs_fall) begin
                        shift_out_d = {next_resp_q, {(WORD_BITS-16){1'b0}}};
                        bit_cnt_d   = '0;
                        state_d     = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        miso_d      = shift_out_q[WORD_BITS-1];
                        shift_out_d = shift_out_q << 1;
                    end
                    if (sclk_fall) begin
                        shift_in_d = {shift_in_q[WORD_BITS-2:0], mosi_s};
                        if (bit_cnt_q != CNT_SAT)
                            bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (cs_rise) begin
                        miso_d  = 1'b0;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = ST_IDLE;
                    if (bit_cnt_q == CNT_FULL) begin
                        cmd_word_d  = c;
                        cmd_valid_d = 1'b1;
                        if (c == OP_NULL) begin
                            next_resp_d = null_resp(ready_q);
                        end else if (c == OP_UNLOCK) begin
                            next_resp_d = OP_UNLOCK;
                            locked_d    = 1'b0;
                            ready_d     = 1'b0;
                        end else if (c == OP_LOCK) begin
                            next_resp_d = OP_LOCK;
                            locked_d    = 1'b1;
                        end else if (c[15:13] == OP_RREG_PFX) begin
                            next_resp_d = {c[15:8], regfile_q[addr]};
                        end else if (c[15:13] == OP_WREG_PFX && !locked_q) begin
                            regfile_d[addr] = c[7:0];
                            next_resp_d     = {OP_RREG_PFX, c[12:0]};
                        end else begin
                            next_resp_d = null_resp(ready_q);
                        end
                    end else begin
`ifdef ADS_RESP_FRAME_ERR_EN
                        frame_err_d = 1'b1;
                        next_resp_d = 16'h0000;
`endif
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end
    end

    // State registers
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            miso_q      <= 1'b0;
            cmd_word_q  <= 16'h0000;
            cmd_valid_q <= 1'b0;
            locked_q    <= 1'b1;
            ready_q     <= 1'b1;
            next_resp_q <= RESP_READY;
            shift_out_q <= '0;
            shift_in_q  <= '0;
            bit_cnt_q   <= '0;
            regfile_q   <= '0;
`ifdef ADS_RESP_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            miso_q      <= miso_d;
            cmd_word_q  <= cmd_word_d;
            cmd_valid_q <= cmd_valid_d;
            locked_q    <= locked_d;
            ready_q     <= ready_d;
            next_resp_q <= next_resp_d;
            shift_out_q <= shift_out_d;
            shift_in_q  <= shift_in_d;
            bit_cnt_q   <= bit_cnt_d;
            regfile_q   <= regfile_d;
`ifdef ADS_RESP_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign SPI_MISO  = miso_q;
    assign cmd_word  = cmd_word_q;
    assign cmd_valid = cmd_valid_q;
    assign locked    = locked_q;
    assign state     = state_q;
`ifdef ADS_RESP_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_ads131_spi_responder.sv
// Bench for ads131_spi_responder: SPI master driving directed frames,
// checked against a frame-level model of the ADC reply/lock rules.
`timescale 1ns/1ps
module tb_ads131_spi_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        spi_rst = 1'b1;
    logic        miso;
    logic [15:0] cmd_word;
    logic        cmd_valid;
    logic        locked;
    logic [1:0]  state;
`ifdef ADS_RESP_FRAME_ERR_EN
    logic        frame_err;
    int          fe_pulses = 0;
`endif

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    ads131_spi_responder dut (
        .system_clock(clk),
        .reset_n(reset_n),
        .SPI_SCLK(sclk),
        .SPI_CS(cs),
        .SPI_MOSI(mosi),
        .SPI_MISO(miso),
        .SPI_RESET(spi_rst),
        .cmd_word(cmd_word),
        .cmd_valid(cmd_valid),
        .locked(locked),
        .state(state)
`ifdef ADS_RESP_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    // Model of the device as seen from the master
    logic [15:0] m_next;
    logic        m_locked;
    logic        m_ready;
    logic [7:0]  m_reg [32];
    logic [15:0] exp_cmd = 16'h0000;
    int          pulses = 0;
    int          cs_hi = 0;
    logic        last_valid = 1'b0;
    logic [31:0] last_resp;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_next   = 16'hFF04;
        m_locked = 1'b1;
        m_ready  = 1'b1;
        for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
    endtask

    function automatic logic [15:0] m_null();
        return m_ready ? 16'hFF04 : 16'h2200;
    endfunction

    task automatic model_frame(input logic [31:0] w, input int nbits);
        logic [15:0] cw;
        int a;
        cw = w[31:16];
        a  = int'(cw[12:8]);
        if (nbits != 32) begin
`ifdef ADS_RESP_FRAME_ERR_EN
            m_next = 16'h0000;
`endif
            return;
        end
        exp_cmd = cw;
        if (cw == 16'h0000) m_next = m_null();
        else if (cw == 16'h0655) begin
            m_next = 16'h0655; m_locked = 1'b0; m_ready = 1'b0;
        end else if (cw == 16'h0555) begin
            m_next = 16'h0555; m_locked = 1'b1;
        end else if (cw[15:13] == 3'd1) m_next = {cw[15:8], m_reg[a]};
        else if (cw[15:13] == 3'd2 && !m_locked) begin
            m_reg[a] = cw[7:0];
            m_next   = {3'b001, cw[12:0]};
        end else m_next = m_null();
    endtask

    // Per-cycle compare: MISO idle while CS high, cmd_word on every pulse
    always @(negedge clk) begin
        if (cs) cs_hi++;
        else cs_hi = 0;
        if (reset_n && cs_hi >= 6) chk("miso_idle", {31'd0, miso}, 32'd0);
        if (cmd_valid) begin
            pulses++;
            chk("cmd_word", {16'd0, cmd_word}, {16'd0, exp_cmd});
            chk("cmd_valid_1cyc", {31'd0, last_valid}, 32'd0);
        end
        last_valid = cmd_valid;
`ifdef ADS_RESP_FRAME_ERR_EN
        if (frame_err) fe_pulses++;
`endif
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_frame(input string nm, input logic [31:0] w,
                             input int nbits);
        logic [31:0] got, exp, mask;
        int p0;
`ifdef ADS_RESP_FRAME_ERR_EN
        int f0;
        f0 = fe_pulses;
`endif
        got  = 32'd0;
        exp  = {m_next, 16'h0000};
        mask = (nbits >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> nbits);
        p0   = pulses;
        model_frame(w, nbits);
        cs = 1'b0;
        wait_clks(4);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = (i < 32) ? w[31-i] : 1'b0;
            wait_clks(5);
            if (i < 32) got[31-i] = miso;
            sclk = 1'b0;
            wait_clks(5);
        end
        wait_clks(2);
        cs = 1'b1;
        wait_clks(8);
        last_resp = got;
        chk({nm, "_miso"}, got & mask, exp & mask);
        chk({nm, "_pulse"}, pulses - p0, (nbits == 32) ? 1 : 0);
        chk({nm, "_locked"}, {31'd0, locked}, {31'd0, m_locked});
`ifdef ADS_RESP_FRAME_ERR_EN
        chk({nm, "_ferr"}, fe_pulses - f0, (nbits == 32) ? 0 : 1);
`endif
    endtask

    initial begin
        model_reset();
        wait_clks(3);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_cmd", {16'd0, cmd_word}, 32'd0);
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd1);
        chk("rst_state", {30'd0, state}, 32'd0);
        reset_n = 1'b1;
        wait_clks(8);
        chk("idle_state", {30'd0, state}, 32'd1);

        run_frame("null1", 32'h0000_0000, 32);
        run_frame("null2", 32'h0000_0000, 32);
        chk("lit_null2", last_resp, 32'hFF04_0000);
        chk("lit_null2_cmd", {16'd0, cmd_word}, 32'h0000);
        run_frame("unlock", 32'h0655_0000, 32);
        run_frame("null3", 32'h0000_0000, 32);
        chk("lit_unlock_resp", last_resp, 32'h0655_0000);
        chk("lit_unlocked", {31'd0, locked}, 32'd0);
        run_frame("null4", 32'h0000_0000, 32);
        chk("lit_status", last_resp, 32'h2200_0000);
        run_frame("wreg", 32'h4305_0000, 32);
        run_frame("rreg", 32'h2300_0000, 32);
        chk("lit_wreg_resp", last_resp, 32'h2305_0000);
        run_frame("null5", 32'h0000_0000, 32);
        chk("lit_rreg_resp", last_resp, 32'h2305_0000);
        run_frame("lock", 32'h0555_0000, 32);
        run_frame("wreg_lk", 32'h4307_0000, 32);
        chk("lit_lock_resp", last_resp, 32'h0555_0000);
        run_frame("rreg2", 32'h2300_0000, 32);
        run_frame("null6", 32'h0000_0000, 32);
        chk("lit_reg_kept", last_resp, 32'h2305_0000);
        run_frame("unlock2", 32'h0655_0000, 32);
        run_frame("short", 32'h0555_0000, 20);
        run_frame("long", 32'h0555_0000, 34);
        run_frame("null7", 32'h0000_0000, 32);
`ifndef ADS_RESP_FRAME_ERR_EN
        chk("lit_drop_keep", last_resp, 32'h0655_0000);
`endif
        chk("lit_drop_unlk", {31'd0, locked}, 32'd0);

        // SPI_RESET asserted part-way through a frame
        cs = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            wait_clks(5);
            sclk = 1'b0;
            wait_clks(5);
        end
        sclk = 1'b1;
        wait_clks(5);
        spi_rst = 1'b0;
        wait_clks(6);
        chk("hrst_miso", {31'd0, miso}, 32'd0);
        chk("hrst_state", {30'd0, state}, 32'd0);
        chk("hrst_locked", {31'd0, locked}, 32'd1);
        sclk = 1'b0;
        cs = 1'b1;
        wait_clks(4);
        spi_rst = 1'b1;
        wait_clks(10);
        model_reset();

        run_frame("null8", 32'h0000_0000, 32);
        chk("lit_after_rst", last_resp, 32'hFF04_0000);
        run_frame("wreg_rst", 32'h4305_0000, 32);
        run_frame("rreg3", 32'h2300_0000, 32);
        run_frame("null9", 32'h0000_0000, 32);
        chk("lit_lk_nowr", last_resp, 32'h2300_0000);
        run_frame("other", 32'h8123_0000, 32);
        run_frame("null10", 32'h0000_0000, 32);
        chk("lit_other", last_resp, 32'hFF04_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
